cla_add32_pipe: RTL and testbench
=================================

# cla_add32_pipe

Two-stage pipelined 32-bit add/subtract datapath built around `cla_unit4`. Stage 1 forms per-bit generate/propagate terms and the carry-in, and registers them. Stage 2 feeds those terms to eight `cla_unit4` groups, a second lookahead level, and the sum/flag logic, and registers the result. The block sits between the ALU operand mux and the ALU result mux, with valid/ready flow control on both sides.

## Interface
Parameters:
- `WIDTH`, 32: operand width; must be a multiple of 16.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operand beat valid.
- `in_ready` out 1: block accepts a beat this cycle.
- `a` in WIDTH: operand A.
- `b` in WIDTH: operand B.
- `sub` in 1: 1 = A−B, 0 = A+B.
- `cin` in 1: carry-in; used only when `sub`=0.
- `out_valid` out 1: result beat valid.
- `out_ready` in 1: downstream accepts the result.
- `sum` out WIDTH: result.
- `cout` out 1: carry out of the MSB.
- `ovf` out 1: signed overflow.
- `zero` out 1: `sum` == 0.

## Operation
Stage 1 captures a beat on `in_valid && in_ready`:
- Effective operand: `b_eff = sub ? ~b : b`.
- Per-bit terms: `P = a ^ b_eff`, `G = a & b_eff`.
- Carry-in: `c0 = sub ? 1 : cin`.
- Registered: `s1_valid`, `G`, `P`, `c0`, and the MSBs of `a` and `b_eff`.

Stage 2:
- Groups: `WIDTH/4` `cla_unit4` groups.
- Group terms: GG = G3|P3G2|P3P2G1|P3P2P1G0; PG = P0&P1&P2&P3.
- Second level: `cla_unit4` instances resolve group carry-ins for each block of 4 groups. Consecutive 16-bit blocks chain through the block carry (block ripple).
- Sum: `sum[i] = P[i] ^ c[i]`.
- Carry out: `cout = c[WIDTH]`.
- Overflow: `ovf = c[WIDTH] ^ c[WIDTH-1]`.
- Zero: `zero = ~|sum`.
- Registered on stage-2 load: `sum`, `cout`, `ovf`, `zero`, `out_valid`.

Flow control (per-stage elastic pipeline, no skid buffer):
- `s2_free = !out_valid || out_ready`.
- `in_ready = !s1_valid || s2_free`.
- Stage 2 loads when `s1_valid && s2_free`.
- `out_valid` clears when `out_ready` is high and stage 2 does not load.
- Stage 1 loads on `in_valid && in_ready`. `s1_valid` clears when stage 2 loads and no new beat arrives.

Behaviour at boundaries:
- Simultaneous stage-2 drain and stage-1 refill in one cycle: both occur; no bubble.
- Stall (`out_ready`=0 with both stages full): all registers hold, `in_ready`=0, and outputs are stable.
- `a`, `b`, `sub`, `cin` are ignored when `in_valid`=0.
- `sub`=1: `cout`=1 means no borrow (A ≥ B unsigned).
- Wrap-around is modular 2^WIDTH; no saturation.

## Timing
- Reset state (async, immediate): `s1_valid`=0, `out_valid`=0, `sum`=0, `cout`=0, `ovf`=0, `zero`=0. `in_ready` is therefore 1 during and after reset.
- Reset mid-operation: in-flight beats are discarded with no partial output. The first accept is legal on the first clock edge after `rst` falls.
- Latency: exactly 2 cycles from accept to `out_valid`, with no stalls.
- Throughput: 1 beat per cycle while `out_ready`=1.
- `in_ready` is combinational from `out_ready` and registered state only. It never depends on `in_valid`.
- Outputs are registered. No combinational path exists from `a`/`b` to `sum`.

## Configuration
- `CLA_ADD32_FLAGS_EN` defined: `ovf` and `zero` are computed and registered as described in Operation.
- `CLA_ADD32_FLAGS_EN` undefined: the flag logic and flag registers are not built, and `ovf` and `zero` are tied to 0. `sum`, `cout`, and the handshake are unchanged.

## Test plan
- Basic add: reset, then a=0x0000_0005, b=0x0000_0003, sub=0, cin=0 → two cycles later sum=0x0000_0008, cout=0, ovf=0, zero=0.
- Full carry chain: a=0xFFFF_FFFF, b=0x0000_0001, sub=0 → sum=0, cout=1, zero=1, ovf=0.
- Subtract with signed overflow: a=0x8000_0000, b=0x0000_0001, sub=1 → sum=0x7FFF_FFFF, cout=1, ovf=1. Then a=3, b=5, sub=1 → sum=0xFFFF_FFFE, cout=0.
- Back-pressure: stream 4 beats (1+1, 2+2, 3+3, 4+4) with `out_ready` low for cycles 2–5. Required: `in_ready`=0 while both stages are full, outputs held stable, results 2, 4, 6, 8 in order with none dropped or duplicated.
- Reset mid-flight: accept 2 beats, assert `rst` asynchronously before they emerge → `out_valid`=0 immediately and no stale result appears after release.
- Macro check: build without `CLA_ADD32_FLAGS_EN` and run 0x7FFF_FFFF+1 → sum=0x8000_0000, ovf=0, zero=0 (tied).

Source files
------------

// File: rtl/cla_add32_pipe.sv
// cla_add32_pipe: two-stage pipelined add/subtract built from 4-bit
// carry-lookahead units. Stage 1 registers per-bit generate/propagate terms
// and the carry-in. Stage 2 resolves the carries through two lookahead levels,
// with 16-bit blocks rippling into each other, and registers the result.
// Define CLA_ADD32_FLAGS_EN to build the ovf/zero flag logic; otherwise the
// flag registers are not built and both flags are tied to 0.

module cla_unit4 (
  input  logic [3:0] g,
  input  logic [3:0] p,
  input  logic       ci,
  output logic [3:0] c,
  output logic       gg,
  output logic       pg
);
  // Lookahead carries into each of the four positions plus the group terms
  always_comb begin
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    pg   = &p;
  end
endmodule

module cla_add32_pipe #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int unsigned NG = WIDTH / 4;
  localparam int unsigned NB = WIDTH / 16;

  logic             s1_valid_q, s1_valid_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] g_q, g_d, p_q, p_d;
  logic             c0_q, c0_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             s2_free, s1_load, s2_load;
  logic [WIDTH-1:0] b_eff, c_bit, sum_next;
  logic [NG-1:0]    grp_g, grp_p, grp_c;
  logic [NB-1:0]    blk_g, blk_p;
  logic [NB:0]      blk_c;

  // Elastic handshake: each stage loads when its downstream slot frees up
  always_comb begin
    s2_free     = !out_valid_q || out_ready;
    in_ready    = !s1_valid_q || s2_free;
    s2_load     = s1_valid_q && s2_free;
    s1_load     = in_valid && in_ready;
    s1_valid_d  = s1_load ? 1'b1 : (s2_load ? 1'b0 : s1_valid_q);
    out_valid_d = s2_load ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
  end

  // Stage 1: effective operand, per-bit generate/propagate and carry-in
  always_comb begin
    b_eff = sub ? ~b : b;
    g_d   = g_q;
    p_d   = p_q;
    c0_d  = c0_q;
    if (s1_load) begin
      g_d  = a & b_eff;
      p_d  = a ^ b_eff;
      c0_d = sub ? 1'b1 : cin;
    end
  end

  // Stage 1 registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      g_q        <= '0;
      p_q        <= '0;
      c0_q       <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      g_q        <= g_d;
      p_q        <= p_d;
      c0_q       <= c0_d;
    end
  end

  assign blk_c[0] = c0_q;

  genvar k, j;
  generate
    for (k = 0; k < NB; k++) begin : g_blk
      cla_unit4 u_lvl2 (
        .g  (grp_g[4*k +: 4]),
        .p  (grp_p[4*k +: 4]),
        .ci (blk_c[k]),
        .c  (grp_c[4*k +: 4]),
        .gg (blk_g[k]),
        .pg (blk_p[k])
      );
      assign blk_c[k+1] = blk_g[k] | (blk_p[k] & blk_c[k]);
    end
    for (j = 0; j < NG; j++) begin : g_grp
      cla_unit4 u_lvl1 (
        .g  (g_q[4*j +: 4]),
        .p  (p_q[4*j +: 4]),
        .ci (grp_c[j]),
        .c  (c_bit[4*j +: 4]),
        .gg (grp_g[j]),
        .pg (grp_p[j])
      );
    end
  endgenerate

  // Stage 2: sum and carry-out, held while the output slot is stalled
  always_comb begin
    sum_next = p_q ^ c_bit;
    sum_d    = sum_q;
    cout_d   = cout_q;
    if (s2_load) begin
      sum_d  = sum_next;
      cout_d = blk_c[NB];
    end
  end

  // Stage 2 registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

`ifdef CLA_ADD32_FLAGS_EN
  logic a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic ovf_q, ovf_d, zero_q, zero_d;

  // Flag terms: ovf uses the registered operand MSBs, which is equivalent to
  // c[WIDTH]^c[WIDTH-1] (overflow iff equal-sign operands give a differing sum sign)
  always_comb begin
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    if (s1_load) begin
      a_msb_d = a[WIDTH-1];
      b_msb_d = b_eff[WIDTH-1];
    end
    if (s2_load) begin
      ovf_d  = (a_msb_q == b_msb_q) && (sum_next[WIDTH-1] != a_msb_q);
      zero_d = ~|sum_next;
    end
  end

  // Flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign ovf  = ovf_q;
  assign zero = zero_q;
`else
  assign ovf  = 1'b0;
  assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_cla_add32_pipe.sv
// Directed testbench for cla_add32_pipe. Flag expectations follow
// CLA_ADD32_FLAGS_EN: with it undefined, ovf and zero must read 0.
`timescale 1ns/1ps
module tb_cla_add32_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] a, b;
  logic        sub, cin;
  logic        out_valid, out_ready;
  logic [31:0] sum;
  logic        cout, ovf, zero;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

`ifdef CLA_ADD32_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  cla_add32_pipe #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want $finish");
    $fatal(1);
  end

  // Issue one beat into an idle pipe and capture its result and latency
  // (latency 0 means no result appeared within the budget).
  task automatic run_single(input logic [31:0] ta, input logic [31:0] tb,
                            input logic ts, input logic tc,
                            output logic [31:0] rs, output logic rc,
                            output logic ro, output logic rz, output int lat);
    @(negedge clk);
    in_valid = 1'b1; a = ta; b = tb; sub = ts; cin = tc; out_ready = 1'b1;
    lat = 0; rs = '0; rc = 1'b0; ro = 1'b0; rz = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      in_valid = 1'b0; a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
      if (out_valid) begin
        lat = i; rs = sum; rc = cout; ro = ovf; rz = zero;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else pass_cnt++;
    total_cnt++; if (sum !== 32'h0) $display("FAIL reset_sum: got %h want 0", sum); else pass_cnt++;
    total_cnt++; if (cout !== 1'b0) $display("FAIL reset_cout: got %b want 0", cout); else pass_cnt++;
    total_cnt++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else pass_cnt++;
    total_cnt++; if (zero !== 1'b0) $display("FAIL reset_zero: got %b want 0", zero); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_basic_add();
    logic [31:0] s; logic c, o, z; int lat;
    run_single(32'h5, 32'h3, 1'b0, 1'b0, s, c, o, z, lat);
    total_cnt++; if (lat !== 2) $display("FAIL add_latency: got %0d want 2", lat); else pass_cnt++;
    total_cnt++; if (s !== 32'h8) $display("FAIL add_sum: got %h want 00000008", s); else pass_cnt++;
    total_cnt++; if (c !== 1'b0) $display("FAIL add_cout: got %b want 0", c); else pass_cnt++;
    total_cnt++; if (o !== 1'b0) $display("FAIL add_ovf: got %b want 0", o); else pass_cnt++;
    total_cnt++; if (z !== 1'b0) $display("FAIL add_zero: got %b want 0", z); else pass_cnt++;
  endtask

  task automatic test_carry_chain();
    logic [31:0] s; logic c, o, z; int lat;
    run_single(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, s, c, o, z, lat);
    total_cnt++; if (s !== 32'h0) $display("FAIL chain_sum: got %h want 00000000", s); else pass_cnt++;
    total_cnt++; if (c !== 1'b1) $display("FAIL chain_cout: got %b want 1", c); else pass_cnt++;
    total_cnt++; if (z !== FLAGS) $display("FAIL chain_zero: got %b want %b", z, FLAGS); else pass_cnt++;
    total_cnt++; if (o !== 1'b0) $display("FAIL chain_ovf: got %b want 0", o); else pass_cnt++;
    run_single(32'h0000_FFFF, 32'h0, 1'b0, 1'b1, s, c, o, z, lat);
    total_cnt++; if (s !== 32'h0001_0000) $display("FAIL cin_block_sum: got %h want 00010000", s); else pass_cnt++;
    total_cnt++; if (c !== 1'b0) $display("FAIL cin_block_cout: got %b want 0", c); else pass_cnt++;
  endtask

  task automatic test_subtract();
    logic [31:0] s; logic c, o, z; int lat;
    run_single(32'h8000_0000, 32'h1, 1'b1, 1'b0, s, c, o, z, lat);
    total_cnt++; if (s !== 32'h7FFF_FFFF) $display("FAIL sub_ovf_sum: got %h want 7fffffff", s); else pass_cnt++;
    total_cnt++; if (c !== 1'b1) $display("FAIL sub_ovf_cout: got %b want 1", c); else pass_cnt++;
    total_cnt++; if (o !== FLAGS) $display("FAIL sub_ovf_ovf: got %b want %b", o, FLAGS); else pass_cnt++;
    run_single(32'h3, 32'h5, 1'b1, 1'b0, s, c, o, z, lat);
    total_cnt++; if (s !== 32'hFFFF_FFFE) $display("FAIL sub_borrow_sum: got %h want fffffffe", s); else pass_cnt++;
    total_cnt++; if (c !== 1'b0) $display("FAIL sub_borrow_cout: got %b want 0", c); else pass_cnt++;
    total_cnt++; if (o !== 1'b0) $display("FAIL sub_borrow_ovf: got %b want 0", o); else pass_cnt++;
    total_cnt++; if (z !== 1'b0) $display("FAIL sub_borrow_zero: got %b want 0", z); else pass_cnt++;
    run_single(32'd10, 32'd3, 1'b1, 1'b1, s, c, o, z, lat);
    total_cnt++; if (s !== 32'd7) $display("FAIL sub_cin_ignored_sum: got %h want 00000007", s); else pass_cnt++;
    total_cnt++; if (c !== 1'b1) $display("FAIL sub_cin_ignored_cout: got %b want 1", c); else pass_cnt++;
  endtask

  task automatic test_add_overflow();
    logic [31:0] s; logic c, o, z; int lat;
    run_single(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, s, c, o, z, lat);
    total_cnt++; if (s !== 32'h8000_0000) $display("FAIL add_ovf_sum: got %h want 80000000", s); else pass_cnt++;
    total_cnt++; if (c !== 1'b0) $display("FAIL add_ovf_cout: got %b want 0", c); else pass_cnt++;
    total_cnt++; if (o !== FLAGS) $display("FAIL add_ovf_ovf: got %b want %b", o, FLAGS); else pass_cnt++;
    total_cnt++; if (z !== 1'b0) $display("FAIL add_ovf_zero: got %b want 0", z); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] got[$];
    int          gcyc[$];
    int          idx = 0;
    int          not_ready = 0;
    logic [31:0] exp_sum[3] = '{32'd101, 32'd202, 32'd303};
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (idx < 3) begin
        in_valid = 1'b1; a = 32'(100 * (idx + 1)); b = 32'(idx + 1); sub = 1'b0; cin = 1'b0;
      end else in_valid = 1'b0;
      #1;
      if (!in_ready) not_ready++;
      if (out_valid && out_ready) begin got.push_back(sum); gcyc.push_back(cyc); end
      if (in_valid && in_ready) idx++;
    end
    in_valid = 1'b0;
    total_cnt++; if (not_ready !== 0) $display("FAIL b2b_in_ready: got %0d low cycles want 0", not_ready); else pass_cnt++;
    total_cnt++; if (got.size() !== 3) $display("FAIL b2b_count: got %0d want 3", got.size()); else pass_cnt++;
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      total_cnt++; if (got[i] !== exp_sum[i]) $display("FAIL b2b_sum%0d: got %h want %h", i, got[i], exp_sum[i]); else pass_cnt++;
      if (i > 0) begin
        total_cnt++; if (gcyc[i] !== gcyc[i-1] + 1) $display("FAIL b2b_gap%0d: got cycle %0d want %0d", i, gcyc[i], gcyc[i-1] + 1); else pass_cnt++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] got[$];
    int          idx = 0;
    logic [31:0] exp_sum[4] = '{32'd2, 32'd4, 32'd6, 32'd8};
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 2 && cyc <= 5);
      if (idx < 4) begin
        in_valid = 1'b1; a = 32'(idx + 1); b = 32'(idx + 1); sub = 1'b0; cin = 1'b0;
      end else in_valid = 1'b0;
      #1;
      if (cyc >= 2 && cyc <= 5) begin
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready c%0d: got %b want 0", cyc, in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL stall_out_valid c%0d: got %b want 1", cyc, out_valid); else pass_cnt++;
        total_cnt++; if (sum !== 32'd2) $display("FAIL stall_sum c%0d: got %h want 00000002", cyc, sum); else pass_cnt++;
      end
      if (out_valid && out_ready) got.push_back(sum);
      if (in_valid && in_ready) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    total_cnt++; if (got.size() !== 4) $display("FAIL bp_count: got %0d want 4", got.size()); else pass_cnt++;
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      total_cnt++; if (got[i] !== exp_sum[i]) $display("FAIL bp_sum%0d: got %h want %h", i, got[i], exp_sum[i]); else pass_cnt++;
    end
  endtask

  task automatic test_reset_midflight();
    int          stale = 0;
    logic [31:0] s; logic c, o, z; int lat;
    out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b1; a = 32'd7; b = 32'd1; sub = 1'b0; cin = 1'b0;
    @(negedge clk); in_valid = 1'b1; a = 32'd9; b = 32'd1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_mid_out_valid: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (sum !== 32'h0) $display("FAIL rst_mid_sum: got %h want 00000000", sum); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); else pass_cnt++;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    total_cnt++; if (stale !== 0) $display("FAIL rst_mid_stale: got %0d valid cycles want 0", stale); else pass_cnt++;
    run_single(32'd1, 32'd1, 1'b0, 1'b0, s, c, o, z, lat);
    total_cnt++; if (lat !== 2) $display("FAIL rst_recover_latency: got %0d want 2", lat); else pass_cnt++;
    total_cnt++; if (s !== 32'd2) $display("FAIL rst_recover_sum: got %h want 00000002", s); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_carry_chain();
    test_subtract();
    test_add_overflow();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
